mem_stage_seq: RTL

- Parametrised MEM-stage sequencer for the pipelined core; sits between the EX/MEM pipeline register and the data cache.
- Runs plain, byte and multi-level indirect (LDI/STI-style, generalised to N levels) loads and stores as a single FSM.
- Holds the pipeline with `stall` until the final cache response arrives.
- Supports a flush that squashes the request without violating the cache handshake.

---
 rtl/lc3b_types.sv | 10 +
 rtl/byte_lane_mask.sv | 23 ++
 rtl/mem_stage_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline memory stage.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    DATA = 2'd2
  } mem_seq_state_t;

endpackage

// File: rtl/byte_lane_mask.sv
// Byte-lane steering for the data cache: write mask and store-data replication.
module byte_lane_mask #(
  parameter int WIDTH = 16,
  parameter int LANES = WIDTH / 8,
  parameter int SELW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             byte_en,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] data,
  output logic [LANES-1:0] mask,
  output logic [WIDTH-1:0] lane_data
);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mask[i] = !byte_en || (LANES == 1) || (sel == SELW'(i));
    end
  end

  // A byte store puts the same byte on every lane; the mask picks the one that lands.
  assign lane_data = byte_en ? {LANES{data[7:0]}} : data;

endmodule

// File: rtl/mem_stage_seq.sv
// MEM-stage sequencer: plain, byte and N-level indirect loads/stores towards the
// data cache, holding the pipeline until the final response.
module mem_stage_seq
  import lc3b_types::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_IND = 2,
  parameter int LVLW    = $clog2(MAX_IND + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_read,
  input  logic               req_write,
  input  logic               req_byte,
  input  logic [LVLW-1:0]    req_levels,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic               flush,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [WIDTH/8-1:0] dmem_wmask,
  output logic [WIDTH-1:0]   dmem_address,
  output logic [WIDTH-1:0]   dmem_wdata,
  input  logic               dmem_resp,
  input  logic [WIDTH-1:0]   dmem_rdata,
  output logic               stall,
  output logic               done,
  output logic [WIDTH-1:0]   rdata,
  output logic               busy
);

  localparam int LANES = WIDTH / 8;
  localparam int SELW  = (LANES > 1) ? $clog2(LANES) : 1;

  mem_seq_state_t   state, next_state;
  logic [WIDTH-1:0] cur_addr, wdata_q, rdata_q;
  logic [LVLW-1:0]  lvl_q, lvl_in;
  logic             byte_q, write_q, squash;
  logic             accept, kill;
  logic [LANES-1:0] lane_mask;
  logic [WIDTH-1:0] lane_data;

  assign lvl_in = (req_levels > LVLW'(MAX_IND)) ? LVLW'(MAX_IND) : req_levels;
  assign accept = (state == IDLE) && req_valid && (req_read || req_write) && !flush;
  // A flush in the response cycle itself must also suppress done and rdata.
  assign kill   = squash || flush;
  assign busy   = (state != IDLE);
  assign rdata  = rdata_q;

  byte_lane_mask #(.WIDTH(WIDTH)) u_lane (
    .byte_en   (byte_q),
    .sel       (cur_addr[SELW-1:0]),
    .data      (wdata_q),
    .mask      (lane_mask),
    .lane_data (lane_data)
  );

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = '0;
    dmem_address = '0;
    dmem_wdata   = '0;
    stall        = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          next_state = (lvl_in != '0) ? IND : DATA;
        end
      end
      IND: begin
        dmem_read    = 1'b1;
        dmem_address = cur_addr;
        dmem_wmask   = '1;
        stall        = 1'b1;
        if (dmem_resp) begin
          if (kill)                       next_state = IDLE;
          else if (lvl_q == LVLW'(1))     next_state = DATA;
        end
      end
      DATA: begin
        dmem_read    = !write_q;
        dmem_write   = write_q;
        dmem_address = cur_addr;
        dmem_wmask   = lane_mask;
        dmem_wdata   = lane_data;
        stall        = !dmem_resp;
        if (dmem_resp) begin
          next_state = IDLE;
          done       = !kill;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lvl_q    <= '0;
      byte_q   <= 1'b0;
      write_q  <= 1'b0;
      squash   <= 1'b0;
    end else begin
      state  <= next_state;
      squash <= (next_state == IDLE) ? 1'b0 : (squash | (busy & flush));
      if (accept) begin
        cur_addr <= req_addr;
        wdata_q  <= req_wdata;
        byte_q   <= req_byte;
        write_q  <= req_write;
        lvl_q    <= lvl_in;
      end
      if (state == IND && dmem_resp) begin
        cur_addr <= dmem_rdata;
        lvl_q    <= lvl_q - LVLW'(1);
      end
      if (state == DATA && dmem_resp && !write_q && !kill) rdata_q <= dmem_rdata;
    end
  end

endmodule
